// File: rtl/pfd_tdc.sv
// -----------------------------------------------------------------------------
// pfd_tdc -- phase/frequency detector with a time-to-digital counter.
//
// The reference clock `in` and the feedback clock `fb` are asynchronous to
// `clk`. Each is brought into the clk domain, its rising edges are turned into
// one-cycle pulses (eu for in, ed for fb), and a three-state FSM measures how
// many clk cycles separate the leading edge from the lagging one. The result
// is a signed error: positive when the reference leads, negative when the
// feedback leads.
//
// Optional feature (compile-time macro PFD_TDC_LOCK_DET_EN):
//   when defined, a lock detector counts consecutive small, unsaturated
//   results and raises `lock`; when undefined, `lock` is tied low and no lock
//   logic exists.
//
// Parameters
//   CNT_W        width of the magnitude counter (clk cycles)
//   SYNC_STAGES  synchroniser depth on in and fb (>= 2)
//   LOCK_WIN     largest |err| treated as in-lock
//   LOCK_CYCLES  consecutive in-window results needed to assert lock
//
// Ports
//   clk        in   sampling clock, all state on its rising edge
//   rst        in   asynchronous active-high reset
//   in         in   asynchronous reference clock
//   fb         in   asynchronous feedback (divided DCO) clock
//   enable     in   detector enable (synchronous to clk)
//   flagu      out  high while the reference leads
//   flagd      out  high while the feedback leads
//   err        out  signed phase error in clk cycles, held between strobes
//   err_valid  out  one-cycle strobe qualifying err
//   sat        out  sticky counter-saturation flag
//   lock       out  lock indication
//
// Latency: err_valid rises SYNC_STAGES+2 cycles after the closing edge is
// captured by the first synchroniser flop.
// -----------------------------------------------------------------------------
module pfd_tdc #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_WIN    = 2,
    parameter int LOCK_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in,
    input  logic                    fb,
    input  logic                    enable,
    output logic                    flagu,
    output logic                    flagd,
    output logic signed [CNT_W:0]   err,
    output logic                    err_valid,
    output logic                    sat,
    output logic                    lock
);

    if (SYNC_STAGES < 2 || LOCK_WIN < 0 || LOCK_CYCLES < 1) begin : g_bad_params
        $error("pfd_tdc: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DN   = 2'd2
    } state_t;

    // Saturating increment: the counter sticks at its maximum, never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Synchronisers and registered rising-edge detectors.
    // The detector registers the synchroniser output (cap) and keeps one
    // cycle of history (hist); the pulse itself is a register as well.
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_in_q, sync_fb_q;
    logic                   cap_in_q, cap_fb_q;
    logic                   hist_in_q, hist_fb_q;
    logic                   eu_q, ed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_in_q <= '0;
            sync_fb_q <= '0;
            cap_in_q  <= 1'b0;
            cap_fb_q  <= 1'b0;
            hist_in_q <= 1'b0;
            hist_fb_q <= 1'b0;
            eu_q      <= 1'b0;
            ed_q      <= 1'b0;
        end else begin
            sync_in_q <= {sync_in_q[SYNC_STAGES-2:0], in};
            sync_fb_q <= {sync_fb_q[SYNC_STAGES-2:0], fb};
            cap_in_q  <= sync_in_q[SYNC_STAGES-1];
            cap_fb_q  <= sync_fb_q[SYNC_STAGES-1];
            hist_in_q <= cap_in_q;
            hist_fb_q <= cap_fb_q;
            eu_q      <= cap_in_q & ~hist_in_q;
            ed_q      <= cap_fb_q & ~hist_fb_q;
        end
    end

    // ---------------------------------------------------------------------
    // Measurement FSM and counter.
    // ---------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic signed [CNT_W:0]  err_q, err_d;
    logic                   err_valid_q, err_valid_d;
    logic                   sat_q, sat_d;
    logic                   flagu_q, flagd_q;
    logic                   en_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        err_valid_d = 1'b0;
        sat_d       = sat_q;

        // en_q low marks the first enabled cycle: pulses landing there are
        // dropped so a measurement always starts cleanly from IDLE.
        if (!enable || !en_q) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eu_q && ed_q) begin
                        err_d       = '0;
                        err_valid_d = 1'b1;
                    end else if (eu_q) begin
                        state_d = UP;
                        cnt_d   = CNT_W'(1);
                    end else if (ed_q) begin
                        state_d = DN;
                        cnt_d   = CNT_W'(1);
                    end
                end
                UP: begin
                    if (ed_q) begin
                        err_d       = $signed({1'b0, cnt_q});
                        err_valid_d = 1'b1;
                        // A coincident reference edge opens the next cycle.
                        if (eu_q) begin
                            state_d = UP;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        // Extra reference edges (frequency error) keep counting.
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                DN: begin
                    if (eu_q) begin
                        err_d       = -$signed({1'b0, cnt_q});
                        err_valid_d = 1'b1;
                        if (ed_q) begin
                            state_d = DN;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = sat_inc(cnt_q);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (cnt_d == CNT_MAX) begin
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            err_q       <= '0;
            err_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            flagu_q     <= 1'b0;
            flagd_q     <= 1'b0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_valid_q <= err_valid_d;
            sat_q       <= sat_d;
            flagu_q     <= (state_d == UP);
            flagd_q     <= (state_d == DN);
            en_q        <= enable;
        end
    end

    assign flagu     = flagu_q;
    assign flagd     = flagd_q;
    assign err       = err_q;
    assign err_valid = err_valid_q;
    assign sat       = sat_q;

`ifdef PFD_TDC_LOCK_DET_EN
    // ---------------------------------------------------------------------
    // Lock detector: evaluated on the same edge that registers err_valid,
    // so lock changes together with the strobe that caused it.
    // ---------------------------------------------------------------------
    localparam int LK_W = $clog2(LOCK_CYCLES + 1);

    logic [LK_W-1:0] lk_cnt_q, lk_cnt_d;
    logic            lock_q, lock_d;
    logic            in_win;

    function automatic logic [CNT_W:0] err_mag(input logic signed [CNT_W:0] e);
        return e[CNT_W] ? $unsigned(-e) : $unsigned(e);
    endfunction

    always_comb begin
        lk_cnt_d = lk_cnt_q;
        lock_d   = lock_q;
        in_win   = (err_mag(err_d) <= (CNT_W+1)'(LOCK_WIN)) && !sat_d;
        if (err_valid_d) begin
            if (in_win) begin
                if (lk_cnt_q != LK_W'(LOCK_CYCLES)) begin
                    lk_cnt_d = lk_cnt_q + 1'b1;
                end
                lock_d = (lk_cnt_d == LK_W'(LOCK_CYCLES));
            end else begin
                lk_cnt_d = '0;
                lock_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lk_cnt_q <= '0;
            lock_q   <= 1'b0;
        end else begin
            lk_cnt_q <= lk_cnt_d;
            lock_q   <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

endmodule
